// File: rtl/mxu_tile_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mxu_tile_sequencer_if
//  Purpose  : Command, scratch-memory and systolic-array bundle between the
//             tile sequencer (master) and its host/memory/array (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mxu_tile_sequencer_if #(
    parameter int NUM_SIZE  = 16,
    parameter int GRID_SIZE = 2,
    parameter int ADDR_LEN  = 5
);
    // command handshake
    logic                                      cmd_valid;
    logic                                      cmd_ready;
    logic [ADDR_LEN-1:0]                       cmd_a_addr;
    logic [ADDR_LEN-1:0]                       cmd_b_addr;
    logic [ADDR_LEN-1:0]                       cmd_c_addr;
    logic                                      cmd_accumulate;
    // scratch memory
    logic [ADDR_LEN-1:0]                       mem_rd_addr;
    logic [NUM_SIZE-1:0]                       mem_rd_data;
    logic                                      mem_wr_en;
    logic [ADDR_LEN-1:0]                       mem_wr_addr;
    logic [NUM_SIZE-1:0]                       mem_wr_data;
    // systolic array
    logic                                      mxu_ce;
    logic                                      mxu_clear;
    logic [GRID_SIZE*NUM_SIZE-1:0]             west_input;
    logic [GRID_SIZE*NUM_SIZE-1:0]             north_input;
    logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0]   mxu_result;
    // status
    logic                                      busy;
    logic                                      done;
    logic                                      err;

    modport master (
        input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_accumulate,
        input  mem_rd_data, mxu_result,
        output cmd_ready, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output mxu_ce, mxu_clear, west_input, north_input,
        output busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_accumulate,
        output mem_rd_data, mxu_result,
        input  cmd_ready, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mxu_ce, mxu_clear, west_input, north_input,
        input  busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/mxu_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mxu_tile_sequencer
//  Purpose  : Loads A/B tiles from scratch memory, feeds them skewed into an
//             N x N systolic array, and writes C (optionally C += A*B) back
//             row-major, with base-address range checking.
//  Revision : 1.0 - initial release
// ============================================================================
module mxu_tile_sequencer #(
    parameter int NUM_SIZE      = 16,
    parameter int GRID_SIZE     = 2,
    parameter int ADDR_LEN      = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mxu_tile_sequencer_if.master bus
);
    localparam int c_nn       = GRID_SIZE * GRID_SIZE;
    localparam int c_load_len = 2 * c_nn;
    localparam int c_feed_len = 2 * GRID_SIZE - 1;
    localparam int c_cnt_w    = $clog2(c_load_len + c_feed_len + SETTLE_CYCLES + 1);

    localparam logic [ADDR_LEN:0] c_span     = (ADDR_LEN+1)'(c_nn - 1);
    localparam logic [ADDR_LEN:0] c_addr_max = {1'b0, {ADDR_LEN{1'b1}}};

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_clear  = 3'd2;
    localparam logic [2:0] c_st_feed   = 3'd3;
    localparam logic [2:0] c_st_settle = 3'd4;
    localparam logic [2:0] c_st_write  = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;

    logic [2:0]          state_q,  state_d;
    logic [c_cnt_w-1:0]  cnt_q,    cnt_d;
    logic [ADDR_LEN-1:0] a_addr_q, a_addr_d;
    logic [ADDR_LEN-1:0] b_addr_q, b_addr_d;
    logic [ADDR_LEN-1:0] c_addr_q, c_addr_d;
    logic                acc_q,    acc_d;
    logic                err_q,    err_d;
    logic [NUM_SIZE-1:0] a_q [c_nn];
    logic [NUM_SIZE-1:0] a_d [c_nn];
    logic [NUM_SIZE-1:0] b_q [c_nn];
    logic [NUM_SIZE-1:0] b_d [c_nn];

    logic [ADDR_LEN:0]   w_a_end, w_b_end, w_c_end;
    logic                w_range_bad;
    logic [NUM_SIZE-1:0] w_res;

    // Last word touched by each tile, one bit wider so an overrun is visible
    always_comb begin
        w_a_end     = {1'b0, bus.cmd_a_addr} + c_span;
        w_b_end     = {1'b0, bus.cmd_b_addr} + c_span;
        w_c_end     = {1'b0, bus.cmd_c_addr} + c_span;
        w_range_bad = (w_a_end > c_addr_max) || (w_b_end > c_addr_max) ||
                      (w_c_end > c_addr_max);
    end

    // State and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_st_idle;
            cnt_q    <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            acc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            c_addr_q <= c_addr_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    // Tile storage: pure datapath, only meaningful after a full LOAD
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // Next state, phase counter, command latch and sticky error
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        c_addr_d = c_addr_q;
        acc_d    = acc_q;
        err_d    = err_q;
        case (state_q)
            c_st_idle: begin
                if (bus.cmd_valid) begin
                    a_addr_d = bus.cmd_a_addr;
                    b_addr_d = bus.cmd_b_addr;
                    c_addr_d = bus.cmd_c_addr;
                    acc_d    = bus.cmd_accumulate;
                    err_d    = w_range_bad;
                    cnt_d    = '0;
                    state_d  = w_range_bad ? c_st_done : c_st_load;
                end
            end
            c_st_load: begin
                if (cnt_q == c_cnt_w'(c_load_len - 1)) begin
                    cnt_d   = '0;
                    state_d = c_st_clear;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_clear: begin
                cnt_d   = '0;
                state_d = c_st_feed;
            end
            c_st_feed: begin
                if (cnt_q == c_cnt_w'(c_feed_len - 1)) begin
                    cnt_d   = '0;
                    state_d = (SETTLE_CYCLES > 0) ? c_st_settle : c_st_write;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_settle: begin
                if (cnt_q == c_cnt_w'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = c_st_write;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_write: begin
                if (cnt_q == c_cnt_w'(c_nn - 1)) begin
                    cnt_d   = '0;
                    state_d = c_st_done;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_done: state_d = c_st_idle;
            default: begin
                cnt_d   = '0;
                state_d = c_st_idle;
            end
        endcase
    end

    // Capture A during the first half of LOAD and B during the second half
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (state_q == c_st_load) begin
            if (int'(cnt_q) < c_nn) a_d[int'(cnt_q)]        = bus.mem_rd_data;
            else                    b_d[int'(cnt_q) - c_nn] = bus.mem_rd_data;
        end
    end

    // Per-state outputs; feeds are the diagonal skew of A rows and B columns
    always_comb begin
        int lag;
        lag             = 0;
        w_res           = '0;
        bus.cmd_ready   = (state_q == c_st_idle);
        bus.busy        = (state_q != c_st_idle);
        bus.done        = (state_q == c_st_done);
        bus.err         = err_q;
        bus.mem_rd_addr = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        bus.mxu_ce      = 1'b0;
        bus.mxu_clear   = 1'b0;
        bus.west_input  = '0;
        bus.north_input = '0;
        case (state_q)
            c_st_load: begin
                if (int'(cnt_q) < c_nn) bus.mem_rd_addr = a_addr_q + ADDR_LEN'(cnt_q);
                else bus.mem_rd_addr = b_addr_q + ADDR_LEN'(int'(cnt_q) - c_nn);
            end
            c_st_clear: bus.mxu_clear = 1'b1;
            c_st_feed: begin
                bus.mxu_ce = 1'b1;
                for (int i = 0; i < GRID_SIZE; i++) begin
                    lag = int'(cnt_q) - i;
                    if (lag >= 0 && lag < GRID_SIZE) begin
                        bus.west_input[i*NUM_SIZE +: NUM_SIZE]  = a_q[i*GRID_SIZE + lag];
                        bus.north_input[i*NUM_SIZE +: NUM_SIZE] = b_q[lag*GRID_SIZE + i];
                    end
                end
            end
            c_st_settle: bus.mxu_ce = 1'b1;
            c_st_write: begin
                // A reset asserted mid-write suppresses the in-flight write
                bus.mem_wr_en   = !rst;
                bus.mem_wr_addr = c_addr_q + ADDR_LEN'(cnt_q);
                w_res           = bus.mxu_result[int'(cnt_q)*NUM_SIZE +: NUM_SIZE];
                if (acc_q) begin
                    bus.mem_rd_addr = bus.mem_wr_addr;
                    bus.mem_wr_data = w_res + bus.mem_rd_data;
                end else begin
                    bus.mem_wr_data = w_res;
                end
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mxu_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mxu_tile_sequencer
//  Purpose  : Directed self-checking bench for the tile sequencer, N=2 and
//             N=4 instances, each with a memory and a systolic array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mxu_tile_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mxu_tile_sequencer_if #(.NUM_SIZE(16), .GRID_SIZE(2), .ADDR_LEN(5)) bus2 ();
    mxu_tile_sequencer_if #(.NUM_SIZE(16), .GRID_SIZE(4), .ADDR_LEN(6)) bus4 ();

    mxu_tile_sequencer #(.NUM_SIZE(16), .GRID_SIZE(2), .ADDR_LEN(5), .SETTLE_CYCLES(2))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    // the 4x4 array needs N-1 cycles after the last skewed input to drain
    mxu_tile_sequencer #(.NUM_SIZE(16), .GRID_SIZE(4), .ADDR_LEN(6), .SETTLE_CYCLES(3))
        u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // ---------------- memories with a bench-side preload port --------------
    logic [15:0] mem2 [32];
    logic [15:0] mem4 [64];
    logic        pre2_en = 1'b0, pre4_en = 1'b0;
    logic [4:0]  pre2_addr = '0;
    logic [5:0]  pre4_addr = '0;
    logic [15:0] pre2_data = '0, pre4_data = '0;

    assign bus2.mem_rd_data = mem2[bus2.mem_rd_addr];
    assign bus4.mem_rd_data = mem4[bus4.mem_rd_addr];

    always @(posedge clk) begin
        if (bus2.mem_wr_en) mem2[bus2.mem_wr_addr] <= bus2.mem_wr_data;
        else if (pre2_en)   mem2[pre2_addr] <= pre2_data;
        if (bus4.mem_wr_en) mem4[bus4.mem_wr_addr] <= bus4.mem_wr_data;
        else if (pre4_en)   mem4[pre4_addr] <= pre4_data;
    end

    // ---------------- output-stationary systolic array models --------------
    logic [15:0] acc2 [4],  wreg2 [4],  nreg2 [4];
    logic [15:0] acc4 [16], wreg4 [16], nreg4 [16];
    logic [15:0] wv2, nv2, wv4, nv4;

    always @(posedge clk) begin
        if (bus2.mxu_clear) begin
            for (int k = 0; k < 4; k++) begin acc2[k] <= '0; wreg2[k] <= '0; nreg2[k] <= '0; end
        end else if (bus2.mxu_ce) begin
            for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
                if (j == 0) wv2 = bus2.west_input[i*16 +: 16];
                else        wv2 = wreg2[i*2 + ((j > 0) ? j-1 : 0)];
                if (i == 0) nv2 = bus2.north_input[j*16 +: 16];
                else        nv2 = nreg2[((i > 0) ? i-1 : 0)*2 + j];
                acc2[i*2+j]  <= acc2[i*2+j] + wv2 * nv2;
                wreg2[i*2+j] <= wv2;
                nreg2[i*2+j] <= nv2;
            end
        end
    end

    always @(posedge clk) begin
        if (bus4.mxu_clear) begin
            for (int k = 0; k < 16; k++) begin acc4[k] <= '0; wreg4[k] <= '0; nreg4[k] <= '0; end
        end else if (bus4.mxu_ce) begin
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
                if (j == 0) wv4 = bus4.west_input[i*16 +: 16];
                else        wv4 = wreg4[i*4 + ((j > 0) ? j-1 : 0)];
                if (i == 0) nv4 = bus4.north_input[j*16 +: 16];
                else        nv4 = nreg4[((i > 0) ? i-1 : 0)*4 + j];
                acc4[i*4+j]  <= acc4[i*4+j] + wv4 * nv4;
                wreg4[i*4+j] <= wv4;
                nreg4[i*4+j] <= nv4;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++)  bus2.mxu_result[k*16 +: 16] = acc2[k];
        for (int k = 0; k < 16; k++) bus4.mxu_result[k*16 +: 16] = acc4[k];
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // called at a negedge; the write lands on the following posedge
    task automatic poke2(input int addr, input logic [15:0] d);
        pre2_en = 1'b1; pre2_addr = addr[4:0]; pre2_data = d;
        @(negedge clk);
        pre2_en = 1'b0;
    endtask

    task automatic poke4(input int addr, input logic [15:0] d);
        pre4_en = 1'b1; pre4_addr = addr[5:0]; pre4_data = d;
        @(negedge clk);
        pre4_en = 1'b0;
    endtask

    // Issue one command on the N=2 instance from IDLE and run it to DONE.
    // lat = clock edges from the accept edge to the edge that raises done.
    task automatic run2(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic acc, output int lat, output int nwr, output int nce,
                        output int nclr, output logic err1,
                        output logic [31:0] w1, output logic [31:0] n1);
        bus2.cmd_a_addr = a; bus2.cmd_b_addr = b; bus2.cmd_c_addr = c;
        bus2.cmd_accumulate = acc; bus2.cmd_valid = 1'b1;
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        lat = -1; nwr = 0; nce = 0; nclr = 0; err1 = bus2.err; w1 = '0; n1 = '0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (bus2.mem_wr_en) nwr++;
            if (bus2.mxu_clear) nclr++;
            if (bus2.mxu_ce) begin
                if (nce == 1) begin w1 = bus2.west_input; n1 = bus2.north_input; end
                nce++;
            end
            if (bus2.done) begin lat = k; break; end
        end
        @(negedge clk);
    endtask

    logic [15:0] a4 [16], b4 [16], e4 [16];
    logic [15:0] s4;
    int          lat, nwr, nce, nclr;
    logic        err1, seen_done;
    logic [31:0] w1, n1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus2.cmd_valid = 1'b0; bus2.cmd_a_addr = '0; bus2.cmd_b_addr = '0;
        bus2.cmd_c_addr = '0;  bus2.cmd_accumulate = 1'b0;
        bus4.cmd_valid = 1'b0; bus4.cmd_a_addr = '0; bus4.cmd_b_addr = '0;
        bus4.cmd_c_addr = '0;  bus4.cmd_accumulate = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        chk("rst_ready", bus2.cmd_ready, 1);
        chk("rst_busy",  bus2.busy, 0);
        chk("rst_done",  bus2.done, 0);
        chk("rst_err",   bus2.err, 0);
        chk("rst_wr_en", bus2.mem_wr_en, 0);
        chk("rst_ce",    bus2.mxu_ce, 0);
        chk("rst_clear", bus2.mxu_clear, 0);
        chk("rst_rd_addr", bus2.mem_rd_addr, 0);
        chk("rst_wr_addr", bus2.mem_wr_addr, 0);
        chk("rst_wr_data", bus2.mem_wr_data, 0);
        chk("rst_west",  bus2.west_input, 0);
        chk("rst_north", bus2.north_input, 0);
        chk("rst4_ready", bus4.cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // ---- identity A times B ----
        poke2(0, 1); poke2(1, 0); poke2(2, 0); poke2(3, 1);
        poke2(4, 5); poke2(5, 6); poke2(6, 7); poke2(7, 8);
        run2(5'd0, 5'd4, 5'd8, 1'b0, lat, nwr, nce, nclr, err1, w1, n1);
        chk("id_latency", lat, 18);
        chk("id_writes",  nwr, 4);
        chk("id_ce_cycles", nce, 5);
        chk("id_clear_cycles", nclr, 1);
        chk("id_c00", mem2[8], 5);  chk("id_c01", mem2[9], 6);
        chk("id_c10", mem2[10], 7); chk("id_c11", mem2[11], 8);

        // ---- accumulate: [1 2;3 4]*[5 6;7 8] + 1 ----
        poke2(0, 1); poke2(1, 2); poke2(2, 3); poke2(3, 4);
        for (int i = 8; i < 12; i++) poke2(i, 1);
        run2(5'd0, 5'd4, 5'd8, 1'b1, lat, nwr, nce, nclr, err1, w1, n1);
        chk("acc_c00", mem2[8], 20); chk("acc_c01", mem2[9], 23);
        chk("acc_c10", mem2[10], 44); chk("acc_c11", mem2[11], 51);
        chk("acc_west_t1",  w1, 32'h0003_0002);
        chk("acc_north_t1", n1, 32'h0006_0007);

        // ---- modular wrap: each A*B element is 0x8000, plus C=0x8000 ----
        for (int i = 0; i < 4; i++) poke2(i, 16'h8000);
        poke2(4, 1); poke2(5, 0); poke2(6, 0); poke2(7, 1);
        for (int i = 8; i < 12; i++) poke2(i, 16'h8000);
        run2(5'd0, 5'd4, 5'd8, 1'b1, lat, nwr, nce, nclr, err1, w1, n1);
        for (int i = 0; i < 4; i++) chk($sformatf("wrap_c%0d", i), mem2[8+i], 16'h0000);

        // ---- range error: C tile would end at 33 ----
        run2(5'd0, 5'd4, 5'd30, 1'b0, lat, nwr, nce, nclr, err1, w1, n1);
        chk("rng_latency", lat, 0);
        chk("rng_writes",  nwr, 0);
        chk("rng_ce",      nce, 0);
        chk("rng_err_sticky", bus2.err, 1);
        // next accepted command clears err; A*B here is 0x8000 everywhere
        run2(5'd0, 5'd4, 5'd8, 1'b0, lat, nwr, nce, nclr, err1, w1, n1);
        chk("rec_err_cleared", err1, 0);
        chk("rec_latency", lat, 18);
        chk("rec_c00", mem2[8], 16'h8000);

        // ---- reset after two of the four writes ----
        poke2(0, 1); poke2(1, 0); poke2(2, 0); poke2(3, 1);
        poke2(4, 5); poke2(5, 6); poke2(6, 7); poke2(7, 8);
        for (int i = 8; i < 12; i++) poke2(i, 16'hAAAA);
        bus2.cmd_a_addr = 5'd0; bus2.cmd_b_addr = 5'd4; bus2.cmd_c_addr = 5'd8;
        bus2.cmd_accumulate = 1'b0; bus2.cmd_valid = 1'b1;
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        nwr = 0; seen_done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (bus2.done) seen_done = 1'b1;
            if (bus2.mem_wr_en) begin nwr++; if (nwr == 3) break; end
        end
        chk("mid_reached_3rd_write", nwr, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_ready", bus2.cmd_ready, 1);
        chk("mid_busy",  bus2.busy, 0);
        chk("mid_done",  bus2.done | seen_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_c00", mem2[8], 5);       chk("mid_c01", mem2[9], 6);
        chk("mid_c10", mem2[10], 16'hAAAA); chk("mid_c11", mem2[11], 16'hAAAA);

        // ---- 4x4 random tiles, cmd_valid held across two commands ----
        for (int i = 0; i < 16; i++) begin
            a4[i] = 16'($urandom); b4[i] = 16'($urandom);
            poke4(i, a4[i]); poke4(16 + i, b4[i]);
        end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            s4 = '0;
            for (int m = 0; m < 4; m++) s4 = s4 + a4[i*4+m] * b4[m*4+j];
            e4[i*4+j] = s4;
        end
        bus4.cmd_a_addr = 6'd0; bus4.cmd_b_addr = 6'd16; bus4.cmd_c_addr = 6'd32;
        bus4.cmd_accumulate = 1'b0; bus4.cmd_valid = 1'b1;
        @(negedge clk);
        chk("n4_busy_first", bus4.busy, 1);
        bus4.cmd_accumulate = 1'b1;   // second command: C += A*B
        lat = -1; nwr = 0;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            if (bus4.mem_wr_en) nwr++;
            if (bus4.done) begin lat = k; break; end
        end
        chk("n4_latency_first", lat, 59);
        @(negedge clk);
        chk("n4_idle_ready", bus4.cmd_ready, 1);
        @(negedge clk);
        chk("n4_busy_second", bus4.busy, 1);
        bus4.cmd_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            if (bus4.mem_wr_en) nwr++;
            if (bus4.done) begin lat = k; break; end
        end
        chk("n4_latency_second", lat, 59);
        chk("n4_writes", nwr, 32);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            s4 = e4[k] + e4[k];
            chk($sformatf("n4_c%0d", k), mem4[32+k], s4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
